alu_sequencer: RTL

- Controller that sequences the 8-bit ALU datapath: adder, single-bit shifter, logic unit, and the OSEL output-select mux.
- Accepts one operation at a time over a valid/ready request port and drives OSEL, operands and unit controls.
- Iterates the single-bit shifter for multi-bit shifts, captures Y/C/V, and returns result plus Z/N flags over a valid/ready response port.
- Holds a sticky carry flag so ADC chains across operations.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_sequencer_if.sv | 47 ++++
 rtl/alu_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Encodings shared by the ALU sequencer, its bus interface and the datapath mux.
package alu_pkg;

  localparam logic [1:0] OSEL_ADD   = 2'b00;
  localparam logic [1:0] OSEL_SHIFT = 2'b01;
  localparam logic [1:0] OSEL_LOGIC = 2'b10;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ADC = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_SHR = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  localparam logic [1:0] LOGIC_AND = 2'b00;
  localparam logic [1:0] LOGIC_OR  = 2'b01;
  localparam logic [1:0] LOGIC_XOR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_EXEC  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_RESP  = 2'b11
  } state_t;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request, response and datapath-control bundle of the ALU sequencer.
interface alu_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [AMT_W-1:0] req_amt;

  logic [1:0]       osel;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_cin;
  logic             shift_dir;
  logic [1:0]       logic_fn;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c;
  logic             alu_v;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_y;
  logic             rsp_c;
  logic             rsp_v;
  logic             rsp_z;
  logic             rsp_n;
  logic             busy;

  // Sequencer side
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_amt,
    input  alu_y, alu_c, alu_v, rsp_ready,
    output req_ready, osel, alu_a, alu_b, alu_cin, shift_dir, logic_fn,
    output rsp_valid, rsp_y, rsp_c, rsp_v, rsp_z, rsp_n, busy
  );

  // Requester / consumer / datapath side
  modport master (
    output req_valid, req_op, req_a, req_b, req_amt,
    output alu_y, alu_c, alu_v, rsp_ready,
    input  req_ready, osel, alu_a, alu_b, alu_cin, shift_dir, logic_fn,
    input  rsp_valid, rsp_y, rsp_c, rsp_v, rsp_z, rsp_n, busy
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one ALU operation at a time; iterates the 1-bit shifter and keeps a sticky carry.
//   state    | meaning
//   ST_IDLE  | ready for a request
//   ST_EXEC  | one-cycle adder/logic operation
//   ST_SHIFT | one shifter step per cycle, cnt_q steps left
//   ST_RESP  | result valid, waiting for consumer
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_sequencer_if.slave  bus
);

  state_t           state_q, state_d;
  logic [1:0]       osel_q, osel_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             cin_q, cin_d;
  logic             dir_q, dir_d;
  logic [1:0]       fn_q, fn_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
  logic             rsp_c_q, rsp_c_d;
  logic             rsp_v_q, rsp_v_d;
  logic             cf_q, cf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (!is_shift(bus.req_op))   state_d = ST_EXEC;
          else if (bus.req_amt == '0)  state_d = ST_RESP;
          else                         state_d = ST_SHIFT;
        end
      end
      ST_EXEC:  state_d = ST_RESP;
      ST_SHIFT: if (cnt_q == AMT_W'(1)) state_d = ST_RESP;
      ST_RESP:  if (bus.rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == ST_IDLE);
    bus.rsp_valid = (state_q == ST_RESP);
    bus.busy      = (state_q != ST_IDLE);
    bus.osel      = osel_q;
    bus.alu_a     = alu_a_q;
    bus.alu_b     = alu_b_q;
    bus.alu_cin   = cin_q;
    bus.shift_dir = dir_q;
    bus.logic_fn  = fn_q;
    bus.rsp_y     = rsp_y_q;
    bus.rsp_c     = rsp_c_q;
    bus.rsp_v     = rsp_v_q;
    bus.rsp_z     = (rsp_y_q == '0);
    bus.rsp_n     = rsp_y_q[WIDTH-1];
  end

  // Unit controls are registered at accept so they are stable for the whole EXEC/SHIFT cycle.
  always_comb begin
    osel_d  = osel_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    cin_d   = cin_q;
    dir_d   = dir_q;
    fn_d    = fn_q;
    cnt_d   = cnt_q;
    rsp_y_d = rsp_y_q;
    rsp_c_d = rsp_c_q;
    rsp_v_d = rsp_v_q;
    cf_d    = cf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          alu_a_d = bus.req_a;
          alu_b_d = (bus.req_op == OP_SUB) ? ~bus.req_b : bus.req_b;
          cin_d   = (bus.req_op == OP_SUB) | ((bus.req_op == OP_ADC) & cf_q);
          cnt_d   = bus.req_amt;
          osel_d  = OSEL_ADD;
          case (bus.req_op)
            OP_AND: begin osel_d = OSEL_LOGIC; fn_d = LOGIC_AND; end
            OP_OR:  begin osel_d = OSEL_LOGIC; fn_d = LOGIC_OR;  end
            OP_XOR: begin osel_d = OSEL_LOGIC; fn_d = LOGIC_XOR; end
            OP_SHL, OP_SHR: begin
              dir_d = (bus.req_op == OP_SHR);
              if (bus.req_amt == '0) begin
                rsp_y_d = bus.req_a;
                rsp_c_d = 1'b0;
                rsp_v_d = 1'b0;
              end else begin
                osel_d = OSEL_SHIFT;
              end
            end
            default: ;
          endcase
        end
      end
      ST_EXEC: begin
        rsp_y_d = bus.alu_y;
        rsp_c_d = bus.alu_c;
        rsp_v_d = bus.alu_v;
        osel_d  = OSEL_ADD;
      end
      ST_SHIFT: begin
        alu_a_d = bus.alu_y;
        cnt_d   = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          rsp_y_d = bus.alu_y;
          rsp_c_d = bus.alu_c;
          rsp_v_d = bus.alu_v;
          osel_d  = OSEL_ADD;
        end
      end
      ST_RESP: if (bus.rsp_ready) cf_d = rsp_c_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      osel_q  <= OSEL_ADD;
      alu_a_q <= '0;
      alu_b_q <= '0;
      cin_q   <= 1'b0;
      dir_q   <= 1'b0;
      fn_q    <= LOGIC_AND;
      cnt_q   <= '0;
      rsp_y_q <= '0;
      rsp_c_q <= 1'b0;
      rsp_v_q <= 1'b0;
      cf_q    <= 1'b0;
    end else begin
      osel_q  <= osel_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      cin_q   <= cin_d;
      dir_q   <= dir_d;
      fn_q    <= fn_d;
      cnt_q   <= cnt_d;
      rsp_y_q <= rsp_y_d;
      rsp_c_q <= rsp_c_d;
      rsp_v_q <= rsp_v_d;
      cf_q    <= cf_d;
    end
  end

endmodule
